// File: rtl/text_buffer_pkg.sv
// Shared types and row-mapping helper for the text buffer.
// Combinational only; no latency and no flow control.
package text_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ALL,
    CLR_ROW
  } state_t;

  // Logical row plus offset, folded back into 0..rows-1 without a divider.
  function automatic int unsigned row_map(input int unsigned row,
                                          input int unsigned offset,
                                          input int unsigned rows);
    int unsigned sum;
    sum = row + offset;
    return (sum >= rows) ? sum - rows : sum;
  endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port character RAM: sync write, registered read, read-before-write.
// One-cycle read latency; always ready, no backpressure.
module text_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    o_rdat <= r_mem[i_raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character buffer with offset-based scroll and hardware clear engines.
// Reads one cycle latency; writes, clear and scroll are ignored while busy_o is high.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int               COLS   = 80,
  parameter int               ROWS   = 30,
  parameter int               CHAR_W = 7,
  parameter logic [CHAR_W-1:0] BLANK = CHAR_W'('h20)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [$clog2(COLS)-1:0]   col_w_i,
  input  logic [$clog2(ROWS)-1:0]   row_w_i,
  input  logic [CHAR_W-1:0]         din_i,
  input  logic [$clog2(COLS)-1:0]   col_r_i,
  input  logic [$clog2(ROWS)-1:0]   row_r_i,
  output logic [CHAR_W-1:0]         dout_o,
  input  logic                      clr_i,
  input  logic                      scroll_i,
  output logic                      busy_o
);

  localparam int RW = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RW-1:0]     r_offset;
  logic [RW-1:0]     r_row;
  logic [AW-1:0]     r_cnt;
  logic              r_rd_zero;
  logic              r_rd_blank;
  logic              w_cnt_last;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [CHAR_W-1:0] w_wdat;
  logic [AW-1:0]     w_raddr;
  logic [CHAR_W-1:0] w_ram_q;

  assign w_cnt_last = (r_state == CLR_ALL) ? (r_cnt == AW'(N - 1))
                                           : (r_cnt == AW'(COLS - 1));
  assign w_wr_ok = wr_en_i && (32'(col_w_i) < COLS) && (32'(row_w_i) < ROWS);
  assign w_rd_ok = (32'(col_r_i) < COLS) && (32'(row_r_i) < ROWS);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= CLR_ALL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (clr_i)         w_state_nxt = CLR_ALL;
        else if (scroll_i) w_state_nxt = CLR_ROW;
      end
      CLR_ALL, CLR_ROW: begin
        if (w_cnt_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = CLR_ALL;
    endcase
  end

  // The old top row becomes the new bottom row, so it is the one blanked.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_offset <= '0;
      r_row    <= '0;
      r_cnt    <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      if (clr_i) begin
        r_offset <= '0;
      end else if (scroll_i) begin
        r_row    <= r_offset;
        r_offset <= (r_offset == RW'(ROWS - 1)) ? '0 : r_offset + RW'(1);
      end
    end else begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdat  = BLANK;
    busy_o  = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        w_we    = w_wr_ok;
        w_waddr = AW'(row_map(32'(row_w_i), 32'(r_offset), ROWS) * COLS + 32'(col_w_i));
        w_wdat  = din_i;
      end
      CLR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
      end
      CLR_ROW: begin
        w_we    = 1'b1;
        w_waddr = AW'(32'(r_row) * COLS + 32'(r_cnt));
      end
      default: w_we = 1'b0;
    endcase
  end

  assign w_raddr = w_rd_ok
                 ? AW'(row_map(32'(row_r_i), 32'(r_offset), ROWS) * COLS + 32'(col_r_i))
                 : '0;

  text_buffer_ram #(
    .DEPTH (N),
    .AW    (AW),
    .DW    (CHAR_W)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  (w_wdat),
    .i_raddr (w_raddr),
    .o_rdat  (w_ram_q)
  );

  // RAM contents have no reset, so the output flags supply the reset value and BLANK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_zero  <= 1'b1;
      r_rd_blank <= 1'b0;
    end else begin
      r_rd_zero  <= 1'b0;
      r_rd_blank <= !w_rd_ok;
    end
  end

  assign dout_o = r_rd_zero ? '0 : (r_rd_blank ? BLANK : w_ram_q);

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer on a 4x3 grid; the model holds the logical screen.
module tb_text_buffer;

  localparam int         COLS   = 4;
  localparam int         ROWS   = 3;
  localparam int         CHAR_W = 7;
  localparam logic [6:0] BLANK  = 7'h20;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [1:0] col_w_i;
  logic [1:0] row_w_i;
  logic [6:0] din_i;
  logic [1:0] col_r_i;
  logic [1:0] row_r_i;
  logic [6:0] dout_o;
  logic       clr_i;
  logic       scroll_i;
  logic       busy_o;

  logic [6:0] model [ROWS][COLS];
  logic [6:0] exp_q [$];
  string      tag_q [$];
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk_i = ~clk_i;

  text_buffer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CHAR_W (CHAR_W),
    .BLANK  (BLANK)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (wr_en_i),
    .col_w_i  (col_w_i),
    .row_w_i  (row_w_i),
    .din_i    (din_i),
    .col_r_i  (col_r_i),
    .row_r_i  (row_r_i),
    .dout_o   (dout_o),
    .clr_i    (clr_i),
    .scroll_i (scroll_i),
    .busy_o   (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each pushed read is sampled at the next edge and compared just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), 32'(dout_o), 32'(exp_q.pop_front()));
  endtask

  task automatic push_rd(input int c, input int r, input string tag);
    col_r_i = 2'(c);
    row_r_i = 2'(r);
    if (c < COLS && r < ROWS) exp_q.push_back(model[r][c]);
    else                      exp_q.push_back(BLANK);
    tag_q.push_back(tag);
  endtask

  task automatic rd(input int c, input int r, input string tag);
    push_rd(c, r, tag);
    tick();
  endtask

  task automatic rd_all(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        rd(c, r, $sformatf("%s_r%0dc%0d", tag, r, c));
  endtask

  task automatic wr(input int c, input int r, input logic [6:0] d);
    wr_en_i = 1'b1;
    col_w_i = 2'(c);
    row_w_i = 2'(r);
    din_i   = d;
    tick();
    wr_en_i = 1'b0;
    if (c < COLS && r < ROWS) model[r][c] = d;
  endtask

  task automatic pulse(input logic clr, input logic scr);
    clr_i    = clr;
    scroll_i = scr;
    tick();
    clr_i    = 1'b0;
    scroll_i = 1'b0;
  endtask

  task automatic busy_len(input string tag, input int exp);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      tick();
    end
    check_eq(tag, 32'(n), 32'(exp));
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = BLANK;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = model[r+1][c];
    for (int c = 0; c < COLS; c++) model[ROWS-1][c] = BLANK;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; col_w_i = '0; row_w_i = '0; din_i = '0;
    col_r_i = '0; row_r_i = '0; clr_i = 1'b0; scroll_i = 1'b0;
    model_clear();

    // Reset and post-reset blanking
    tick();
    tick();
    check_eq("rst_busy", 32'(busy_o), 32'd1);
    check_eq("rst_dout", 32'(dout_o), 32'd0);
    rst_i = 1'b0;
    busy_len("rst_clr_len", 12);
    rd_all("rst_blank");

    // Same-cycle write and read of one cell returns the old contents
    wr_en_i = 1'b1; col_w_i = 2'd2; row_w_i = 2'd1; din_i = 7'h41;
    push_rd(2, 1, "rw_collide");
    tick();
    wr_en_i = 1'b0;
    model[1][2] = 7'h41;
    rd(2, 1, "rw_read");

    // Out-of-range write dropped, out-of-range reads blank
    wr(3, 3, 7'h7f);
    rd_all("range_nochg");
    rd(0, 3, "range_rd_c0");
    rd(3, 3, "range_rd_c3");

    // Fill and scroll once
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wr(c, r, 7'(7'h30 + r));
    pulse(1'b0, 1'b1);
    model_scroll();
    busy_len("scroll_len", 4);
    rd_all("scroll1");

    // Write and clear during a scroll are ignored
    pulse(1'b0, 1'b1);
    model_scroll();
    wr_en_i = 1'b1; col_w_i = 2'd0; row_w_i = 2'd0; din_i = 7'h55; clr_i = 1'b1;
    tick();
    wr_en_i = 1'b0; clr_i = 1'b0;
    busy_len("lock_len", 3);
    rd(0, 0, "lock_cell");
    rd_all("scroll2");

    // Write in the scroll cycle lands first, using the old offset
    wr_en_i = 1'b1; col_w_i = 2'd0; row_w_i = 2'd2; din_i = 7'h62; scroll_i = 1'b1;
    tick();
    wr_en_i = 1'b0; scroll_i = 1'b0;
    model[2][0] = 7'h62;
    model_scroll();
    busy_len("wrscr_len", 4);
    rd_all("wrscr");

    // Three more scrolls wrap the offset and empty the screen
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1);
      model_scroll();
      busy_len($sformatf("wrap_len%0d", k), 4);
    end
    rd_all("wrap_blank");

    // Writes through a non-zero offset
    pulse(1'b0, 1'b1);
    model_scroll();
    busy_len("off_len", 4);
    wr(3, 2, 7'h61);
    wr(1, 0, 7'h4b);
    wr(2, 1, 7'h5a);
    rd_all("off_rw");

    // Clear beats scroll in the same cycle
    pulse(1'b1, 1'b1);
    model_clear();
    busy_len("prio_len", 12);
    rd_all("prio_blank");
    wr(0, 0, 7'h11);
    wr(0, 2, 7'h22);
    pulse(1'b0, 1'b1);
    model_scroll();
    busy_len("prio_scroll_len", 4);
    rd_all("prio_scroll");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
# text_buffer

Parametrised character buffer between the text-writing logic and the VGA character renderer. It has one write port and one registered read port, addressed by (column, row), with configurable geometry and character width. It adds two hardware operations: a full-screen clear and a one-line scroll-up. Scroll uses a row-offset register plus a row-clear engine, so the writer never has to copy memory.

## Interface
- `COLS`, 80: text columns per row.
- `ROWS`, 30: text rows.
- `CHAR_W`, 7: character code width in bits.
- `BLANK`, 7'h20: code written by clear/scroll and returned for out-of-range reads. Width is `CHAR_W`.
- `clk_i`  in  1: sole clock; all logic on rising edge.
- `rst_i`  in  1: reset, synchronous and active-high.
- `wr_en_i`  in  1: write strobe.
- `col_w_i`  in  `$clog2(COLS)`: write column.
- `row_w_i`  in  `$clog2(ROWS)`: write logical row.
- `din_i`  in  `CHAR_W`: write data.
- `col_r_i`  in  `$clog2(COLS)`: read column.
- `row_r_i`  in  `$clog2(ROWS)`: read logical row.
- `dout_o`  out  `CHAR_W`: registered read data.
- `clr_i`  in  1: start full clear; single-cycle pulse.
- `scroll_i`  in  1: start scroll-up by one row; single-cycle pulse.
- `busy_o`  out  1: clear engine active.

## Operation
- **Storage:** `COLS*ROWS` entries of `CHAR_W` bits. Index = `prow*COLS + col`.
- **Logical-to-physical row mapping:** `prow = row + offset`, minus `ROWS` if the sum is ≥ `ROWS`. No divider.
- **Offset register:** `offset` ranges 0..`ROWS`-1.
- **Out-of-range addresses:**
  - Write with `col ≥ COLS` or `row ≥ ROWS` is dropped.
  - Read at such an address returns `BLANK`.
- **FSM states:**
  - `IDLE`: accepts external writes, `clr_i` and `scroll_i`.
  - `CLR_ALL`: clear-address counter walks 0..`COLS*ROWS`-1, writing `BLANK` once per cycle, then returns to `IDLE`.
  - `CLR_ROW`: walks columns 0..`COLS`-1 of the target physical row, writing `BLANK`, then returns to `IDLE`.
- **Clear (`clr_i` in `IDLE`):** `offset` ← 0, go to `CLR_ALL`.
- **Scroll (`scroll_i` in `IDLE`):** target physical row = current `offset` (the old top row, which becomes the new bottom row). `offset` ← `offset`+1, wrapping `ROWS`-1 → 0. Go to `CLR_ROW`.
- **Simultaneous events:**
  - `clr_i` and `scroll_i` in the same cycle: clear wins, scroll is discarded.
  - `wr_en_i` with `clr_i`/`scroll_i` in `IDLE`: the write commits first, using the old offset.
- **While `busy_o` is high:**
  - External writes, `clr_i` and `scroll_i` are ignored; there is no queuing.
  - Reads continue. They return old data or `BLANK` depending on clear progress.
- **Reset:**
  - `offset` ← 0, `dout_o` ← 0, `busy_o` ← 1.
  - FSM enters `CLR_ALL` with counter 0, so memory is blanked after every reset.
  - Reset asserted mid-clear or mid-scroll aborts the operation and restarts `CLR_ALL`.

## Timing
- **Read latency:** 1 cycle. `dout_o` at edge n+1 reflects the address sampled at edge n.
- **Read/write collision:** read-before-write. A read and a write to the same cell in the same cycle returns the old contents; the new value is visible from the next read.
- **Write commit:** a write sampled at edge n commits at edge n.
- **Clear duration:** `busy_o` rises the cycle after `clr_i` is sampled and stays high exactly `COLS*ROWS` cycles.
- **Scroll duration:** `busy_o` stays high exactly `COLS` cycles.
- **Post-reset clear:** `busy_o` stays high for `COLS*ROWS` cycles after the first cycle with `rst_i` low.
- **Offset update:** the new `offset` applies to reads/writes from the first cycle after `scroll_i`/`clr_i` is sampled.
- **Counter width:** the clear counter is `$clog2(COLS*ROWS)` bits. Terminal count is compared to `COLS*ROWS`-1, so non-power-of-two geometries never overrun.

## Structure
- **`text_buffer_pkg`:** FSM state enum (`IDLE`, `CLR_ALL`, `CLR_ROW`) and a `row_map` function for the offset addition and conditional subtract.
- **Sub-module `text_buffer_ram`:** simple dual-port RAM, sync write, registered sync read, read-before-write, no reset on contents.
- **Top level:** contains the FSM, `offset`, the clear counter and the write-port mux (engine vs external).

## Test plan
All scenarios use `COLS`=4, `ROWS`=3, `CHAR_W`=7, `BLANK`=7'h20.
- **Reset clear:** `rst_i` for 2 cycles, then low → `busy_o` high 12 cycles, then 0. Every cell reads 7'h20.
- **Write/read:** write 7'h41 at (col 2, row 1); read (2,1) next cycle → `dout_o` = 7'h41 one cycle after the read address. A same-cycle read of (2,1) returns 7'h20.
- **Scroll:** fill row r with 7'h30+r; pulse `scroll_i`.
  - `busy_o` high 4 cycles.
  - Logical row 0 reads 7'h31, row 1 reads 7'h32, row 2 reads 7'h20.
  - Three further scrolls (offset wraps 2 → 0) leave every cell at 7'h20.
- **Busy lockout:** during a scroll, `wr_en_i` at (0,0) with 7'h55 plus `clr_i` → both ignored. After busy, (0,0) still holds its prior value.
- **Priority:** `clr_i` and `scroll_i` in the same cycle → `busy_o` high 12 cycles, `offset` = 0.
- **Range:** write `col_w_i`=3, `row_w_i`=3 (out of range) → no cell changes. Read row 3 → `dout_o` = 7'h20.
